// File: rtl/mode_counter.sv
// Programmable-width up/down/ping-pong counter with prescaler, load, wrap/saturate and terminal-count pulse.
// Optional capture register (cap/cap_val) is built when COUNTER_CAPTURE_EN is defined.
module mode_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [1:0]         mode,
  input  logic               sat,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   limit,
`ifdef COUNTER_CAPTURE_EN
  input  logic               cap,
  output logic [WIDTH-1:0]   cap_val,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               dir
);

  localparam logic [WIDTH-1:0]   CNT_ONE = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PRE_ONE = PRESC_W'(1);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [PRESC_W-1:0] r_pre;
  logic [WIDTH-1:0]   r_count;
  logic               r_tc;
  logic               r_dir;

  logic               w_tick;
  logic [PRESC_W-1:0] w_preNext;
  logic [WIDTH-1:0]   w_countNext;
  logic               w_tcNext;
  logic               w_dirNext;
  logic               w_atUpper;
  logic               w_atZero;
  logic               w_limitZero;

  assign w_atUpper   = (r_count >= limit);
  assign w_atZero    = (r_count == '0);
  assign w_limitZero = (limit == '0);

  // The tick qualifies the step on the same edge that resets the prescaler.
  assign w_tick    = en && (r_pre >= presc);
  assign w_preNext = !en ? r_pre : (w_tick ? '0 : r_pre + PRE_ONE);

  always_comb begin
    w_countNext = r_count;
    w_dirNext   = r_dir;
    w_tcNext    = 1'b0;
    if (w_tick) begin
      case (mode_e'(mode))
        MODE_UP: begin
          w_dirNext = 1'b0;
          if (!w_atUpper) begin
            w_countNext = r_count + CNT_ONE;
          end else begin
            w_tcNext    = 1'b1;
            w_countNext = sat ? limit : '0;
          end
        end
        MODE_DOWN: begin
          w_dirNext = 1'b1;
          if (!w_atZero) begin
            w_countNext = r_count - CNT_ONE;
          end else begin
            w_tcNext    = 1'b1;
            w_countNext = sat ? '0 : limit;
          end
        end
        MODE_PING: begin
          // A zero limit pins the count at 0 while direction keeps flipping.
          if (!r_dir) begin
            if (!w_atUpper) begin
              w_countNext = r_count + CNT_ONE;
            end else begin
              w_dirNext   = 1'b1;
              w_tcNext    = 1'b1;
              w_countNext = w_limitZero ? '0 : limit - CNT_ONE;
            end
          end else begin
            if (!w_atZero) begin
              w_countNext = r_count - CNT_ONE;
            end else begin
              w_dirNext   = 1'b0;
              w_tcNext    = 1'b1;
              w_countNext = w_limitZero ? '0 : CNT_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_dir   <= 1'b0;
    end else if (load) begin
      r_pre   <= '0;
      r_count <= load_val;
      r_tc    <= 1'b0;
    end else begin
      r_pre   <= w_preNext;
      r_count <= w_countNext;
      r_tc    <= w_tcNext;
      r_dir   <= w_dirNext;
    end
  end

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] r_capVal;

  // Captures the pre-edge count, so a capture alongside a load sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_capVal <= '0;
    end else if (cap) begin
      r_capVal <= r_count;
    end
  end

  assign cap_val = r_capVal;
`endif

  assign count = r_count;
  assign tc    = r_tc;
  assign dir   = r_dir;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: vector table, directed corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_mode_counter;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;

  typedef struct {
    logic             rstN;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic [1:0]       mode;
    logic             sat;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0] limit;
    logic             cap;
    logic [WIDTH-1:0] expCount;
    logic             expTc;
    logic             expDir;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [1:0]         mode;
  logic               sat;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   limit;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               dir;
`ifdef COUNTER_CAPTURE_EN
  logic               cap;
  logic [WIDTH-1:0]   cap_val;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  // Behavioural model state
  int mCount, mDir, mTc, mPre, mCap;

  vec_t stim;
  vec_t table1[20];

  mode_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .sat      (sat),
    .presc    (presc),
    .limit    (limit),
`ifdef COUNTER_CAPTURE_EN
    .cap      (cap),
    .cap_val  (cap_val),
`endif
    .count    (count),
    .tc       (tc),
    .dir      (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge from the spec's rules, using pre-edge inputs.
  task automatic modelStep();
    int lim;
    bit tick;
    lim = int'(limit);
    if (!rst_n) begin
      mCount = 0; mDir = 0; mTc = 0; mPre = 0; mCap = 0;
      return;
    end
    if (stim.cap) mCap = mCount;
    if (load) begin
      mCount = int'(load_val);
      mPre   = 0;
      mTc    = 0;
      return;
    end
    tick = en && (mPre >= int'(presc));
    if (en) mPre = tick ? 0 : mPre + 1;
    mTc = 0;
    if (!tick) return;
    case (mode)
      2'b00: begin
        mDir = 0;
        if (mCount < lim) mCount++;
        else begin mCount = sat ? lim : 0; mTc = 1; end
      end
      2'b01: begin
        mDir = 1;
        if (mCount > 0) mCount--;
        else begin mCount = sat ? 0 : lim; mTc = 1; end
      end
      2'b10: begin
        if (mDir == 0) begin
          if (mCount < lim) mCount++;
          else begin mDir = 1; mTc = 1; mCount = (lim == 0) ? 0 : lim - 1; end
        end else begin
          if (mCount > 0) mCount--;
          else begin mDir = 0; mTc = 1; mCount = (lim == 0) ? 0 : 1; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n    = v.rstN;
    en       = v.en;
    load     = v.load;
    load_val = v.loadVal;
    mode     = v.mode;
    sat      = v.sat;
    presc    = v.presc;
    limit    = v.limit;
`ifdef COUNTER_CAPTURE_EN
    cap      = v.cap;
`endif
    stim     = v;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".count"}, int'(count), mCount);
    checkOutput({tag, ".tc"},    int'(tc),    mTc);
    checkOutput({tag, ".dir"},   int'(dir),   mDir);
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic l, input int lv,
                              input int m, input logic s, input int p, input int lim,
                              input int ec, input logic et, input logic ed);
    vec_t v;
    v.rstN = r; v.en = e; v.load = l; v.loadVal = WIDTH'(lv);
    v.mode = 2'(m); v.sat = s; v.presc = PRESC_W'(p); v.limit = WIDTH'(lim);
    v.cap = 1'b0;
    v.expCount = WIDTH'(ec); v.expTc = et; v.expDir = ed;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 2'b00;
    sat = 1'b0; presc = '0; limit = '0;
`ifdef COUNTER_CAPTURE_EN
    cap = 1'b0;
`endif
    stim = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Ping-pong limit=3, then limit=0, then down-wrap with load, then hold.
    table1[0]  = mk(0, 1, 0, 0, 2, 0, 0, 3, 0, 0, 0);
    table1[1]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 1, 0, 0);
    table1[2]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 2, 0, 0);
    table1[3]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 3, 0, 0);
    table1[4]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 2, 1, 1);
    table1[5]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 1, 0, 1);
    table1[6]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 0, 0, 1);
    table1[7]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 1, 1, 0);
    table1[8]  = mk(1, 1, 0, 0, 2, 0, 0, 3, 2, 0, 0);
    table1[9]  = mk(1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1);
    table1[10] = mk(1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0);
    table1[11] = mk(1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1);
    table1[12] = mk(1, 1, 1, 1, 1, 0, 0, 3, 1, 0, 1);
    table1[13] = mk(1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 1);
    table1[14] = mk(1, 1, 0, 0, 1, 0, 0, 3, 3, 1, 1);
    table1[15] = mk(1, 1, 0, 0, 1, 0, 0, 3, 2, 0, 1);
    table1[16] = mk(1, 1, 0, 0, 1, 0, 0, 3, 1, 0, 1);
    table1[17] = mk(1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 1);
    table1[18] = mk(1, 1, 0, 0, 1, 0, 0, 3, 3, 1, 1);
    table1[19] = mk(1, 1, 0, 0, 3, 0, 0, 3, 3, 0, 1);

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(table1[i]);
      checkOutput($sformatf("tbl%0d.count", i), int'(count), int'(table1[i].expCount));
      checkOutput($sformatf("tbl%0d.tc", i),    int'(tc),    int'(table1[i].expTc));
      checkOutput($sformatf("tbl%0d.dir", i),   int'(dir),   int'(table1[i].expDir));
    end

    // Full-range up count: 255 wraps to 0 with a single tc pulse.
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 255, 0, 0, 0));
    checkOutput("wrap.reset", int'(count), 0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 255, 0, 0, 0));
      checkOutput("wrap.count", int'(count), (i + 1) % 256);
      checkOutput("wrap.tc",    int'(tc),    (i == 255) ? 1 : 0);
    end

    // Saturating up count with presc=2, including an en=0 freeze mid-phase.
    applyStimulus(mk(0, 1, 0, 0, 0, 1, 2, 5, 0, 0, 0));
    checkModel("sat.reset");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(mk(1, (i < 10 || i > 14) ? 1'b1 : 1'b0, 0, 0, 0, 1, 2, 5, 0, 0, 0));
      checkModel("sat.run");
    end
    checkOutput("sat.hold", int'(count), 5);

    // Down wrap with a load mid-run restarting the prescaler phase.
    applyStimulus(mk(1, 1, 1, 1, 1, 0, 1, 3, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      applyStimulus(mk(1, 1, (i == 5) ? 1'b1 : 1'b0, 2, 1, 0, 1, 3, 0, 0, 0));
      checkModel("down.run");
    end

    // Reset together with load at count=0x37 clears everything and ignores the load.
    applyStimulus(mk(1, 1, 1, 'h37, 1, 0, 0, 'h80, 0, 0, 0));
    checkOutput("rstld.pre", int'(count), 'h37);
    applyStimulus(mk(0, 1, 1, 'hAA, 1, 0, 0, 'h80, 0, 0, 0));
    checkOutput("rstld.count", int'(count), 0);
    checkOutput("rstld.tc",    int'(tc),    0);
    checkOutput("rstld.dir",   int'(dir),   0);

`ifdef COUNTER_CAPTURE_EN
    begin
      vec_t c;
      applyStimulus(mk(1, 1, 1, 'h12, 0, 0, 0, 'hFF, 0, 0, 0));
      c = mk(1, 1, 0, 0, 0, 0, 0, 'hFF, 0, 0, 0);
      c.cap = 1'b1;
      applyStimulus(c);
      checkOutput("cap.val", int'(cap_val), 'h12);
      for (int i = 0; i < 4; i++) begin
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 'hFF, 0, 0, 0));
        checkOutput("cap.hold", int'(cap_val), 'h12);
      end
      c = mk(1, 1, 1, 'h99, 0, 0, 0, 'hFF, 0, 0, 0);
      c.cap = 1'b1;
      applyStimulus(c);
      checkOutput("cap.withload", int'(cap_val), 'h17);
      checkOutput("cap.loaded",   int'(count),   'h99);
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      vec_t r;
      r = mk(($urandom_range(63) != 0) ? 1'b1 : 1'b0,
             ($urandom_range(7) != 0) ? 1'b1 : 1'b0,
             ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
             int'($urandom_range(255)),
             int'($urandom_range(3)),
             1'($urandom_range(1)),
             int'($urandom_range(3)),
             ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(6)),
             0, 0, 0);
      r.cap = 1'($urandom_range(1));
      applyStimulus(r);
      checkModel("rand");
`ifdef COUNTER_CAPTURE_EN
      checkOutput("rand.cap", int'(cap_val), mCap);
`endif
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
